act_skew_feeder: RTL and testbench

//  Upstream activation feeder for the weight-stationary PE array.
//  - Accepts one ROWS-wide activation vector per handshake.
//  - Skews it diagonally: lane i is delayed i cycles relative to lane 0.
//  - Drives the a_in inputs of the left-column PEs.
//  - Frames a GEMM tile of k_len vectors, then drains the skew pipeline and reports frame completion.

---
 rtl/act_skew_feeder.sv | 149 ++++++++++++++
 tb/tb_act_skew_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Diagonal activation skew feeder for the left column of a weight-stationary PE array.
// Optional FEEDER_CNT_EN adds a 16-bit completed-frame counter output.
module act_skew_feeder #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K_MAX  = 16,
  parameter int unsigned CNT_W  = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   start,
  input  logic [CNT_W-1:0]       k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  output logic [ROWS*DATA_W-1:0] a_out,
  output logic [ROWS-1:0]        a_valid,
  output logic                   busy,
  output logic                   frame_done
`ifdef FEEDER_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int unsigned DRN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      vec_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    vec_d      = vec_q;
    drn_d      = drn_q;
    in_ready   = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start with k_len == 0 is dropped; an in_valid in this cycle is never accepted
        if (start && (k_len != '0)) begin
          state_d = StFeed;
          k_d     = (k_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len;
          vec_d   = '0;
        end
      end
      StFeed: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          vec_d  = vec_q + CNT_W'(1);
          if ((vec_q + CNT_W'(1)) == k_q) begin
            state_d = StDrain;
            drn_d   = '0;
          end
        end
      end
      StDrain: begin
        if (drn_q == DRN_W'(ROWS - 1)) begin
          frame_done = 1'b1;
          state_d    = StIdle;
          vec_d      = '0;
          drn_d      = '0;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything else in the same cycle
    if (clear) begin
      state_d    = StIdle;
      k_d        = '0;
      vec_d      = '0;
      drn_d      = '0;
      accept     = 1'b0;
      frame_done = 1'b0;
    end
  end

  assign busy = (state_q != StIdle);

  // Lane i is an (i+1)-deep shift register; non-accept cycles inject a zero bubble.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DATA_W-1:0] dat_q [i+1];
    logic              val_q [i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
          val_q[j] <= 1'b0;
        end
      end else if (clear) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
          val_q[j] <= 1'b0;
        end
      end else begin
        dat_q[0] <= accept ? in_data[i*DATA_W +: DATA_W] : '0;
        val_q[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dat_q[j] <= dat_q[j-1];
          val_q[j] <= val_q[j-1];
        end
      end
    end

    assign a_out[i*DATA_W +: DATA_W] = dat_q[i];
    assign a_valid[i]                = val_q[i];
  end

`ifdef FEEDER_CNT_EN
  logic [15:0] frame_cnt_q;

  // Survives clear on purpose: only a hard reset zeroes the frame tally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed self-checking bench for act_skew_feeder (ROWS=4, DATA_W=8, K_MAX=16).
module tb_act_skew_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic [4:0]  k_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] a_out;
  logic [3:0]  a_valid;
  logic        busy;
  logic        frame_done;
`ifdef FEEDER_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  act_skew_feeder #(
    .ROWS   (4),
    .DATA_W (8),
    .K_MAX  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .start      (start),
    .k_len      (k_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .a_out      (a_out),
    .a_valid    (a_valid),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef FEEDER_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] vec(input logic [7:0] l0, input logic [7:0] l1,
                                      input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [7:0] lane(input int i);
    return a_out[i*8 +: 8];
  endfunction

`ifdef FEEDER_CNT_EN
  task automatic run_frame();
    logic seen;
    start = 1'b1; k_len = 5'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = vec(8'h1, 8'h2, 8'h3, 8'h4);
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (frame_done) seen = 1'b1;
      else tick();
    end
    chk("run_frame_done_seen", 32'(seen), 32'd1);
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_out", a_out, 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Three back-to-back vectors
    start = 1'b1; k_len = 5'd3;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = vec(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    chk("t1_c1_lane0", 32'(lane(0)), 32'd1);
    chk("t1_c1_valid", 32'(a_valid), 32'b0001);
    in_data = vec(8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    chk("t1_c2_lane0", 32'(lane(0)), 32'd5);
    chk("t1_c2_lane1", 32'(lane(1)), 32'd2);
    chk("t1_c2_valid", 32'(a_valid), 32'b0011);
    in_data = vec(8'd9, 8'd10, 8'd11, 8'd12);
    tick();
    in_valid = 1'b0;
    chk("t1_c3_lane0", 32'(lane(0)), 32'd9);
    chk("t1_c3_lane2", 32'(lane(2)), 32'd3);
    chk("t1_c3_valid", 32'(a_valid), 32'b0111);
    chk("t1_c3_in_ready", 32'(in_ready), 32'd0);
    chk("t1_c3_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c4_lane3", 32'(lane(3)), 32'd4);
    chk("t1_c4_lane0", 32'(lane(0)), 32'd0);
    chk("t1_c4_valid", 32'(a_valid), 32'b1110);
    chk("t1_c4_fd", 32'(frame_done), 32'd0);
    tick();
    chk("t1_c5_lane3", 32'(lane(3)), 32'd8);
    chk("t1_c5_valid", 32'(a_valid), 32'b1100);
    chk("t1_c5_fd", 32'(frame_done), 32'd0);
    tick();
    chk("t1_c6_lane3", 32'(lane(3)), 32'd12);
    chk("t1_c6_valid", 32'(a_valid), 32'b1000);
    chk("t1_c6_fd", 32'(frame_done), 32'd1);
    tick();
    chk("t1_c7_busy", 32'(busy), 32'd0);
    chk("t1_c7_valid", 32'(a_valid), 32'h0);
    chk("t1_c7_a_out", a_out, 32'h0);
    chk("t1_c7_fd", 32'(frame_done), 32'd0);

    // Bubble in mid-frame, start ignored in FEED, in_valid ignored in DRAIN
    start = 1'b1; k_len = 5'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = vec(8'h11, 8'h12, 8'h13, 8'h14);
    tick();
    chk("t2_f1_lane0", 32'(lane(0)), 32'h11);
    chk("t2_f1_valid", 32'(a_valid), 32'b0001);
    in_valid = 1'b0; start = 1'b1; k_len = 5'd5;
    tick();
    start = 1'b0;
    chk("t2_f2_lane0", 32'(lane(0)), 32'h0);
    chk("t2_f2_lane1", 32'(lane(1)), 32'h12);
    chk("t2_f2_valid", 32'(a_valid), 32'b0010);
    in_valid = 1'b1; in_data = vec(8'h21, 8'h22, 8'h23, 8'h24);
    tick();
    in_data = vec(8'h31, 8'h32, 8'h33, 8'h34);
    chk("t2_f3_lane0", 32'(lane(0)), 32'h21);
    chk("t2_f3_valid", 32'(a_valid), 32'b0101);
    chk("t2_f3_in_ready", 32'(in_ready), 32'd0);
    chk("t2_f3_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_f4_lane0", 32'(lane(0)), 32'h0);
    chk("t2_f4_lane3", 32'(lane(3)), 32'h14);
    chk("t2_f4_valid", 32'(a_valid), 32'b1010);
    chk("t2_f4_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t2_f5_lane3", 32'(lane(3)), 32'h0);
    chk("t2_f5_valid", 32'(a_valid), 32'b0100);
    chk("t2_f5_fd", 32'(frame_done), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_f6_lane3", 32'(lane(3)), 32'h24);
    chk("t2_f6_valid", 32'(a_valid), 32'b1000);
    chk("t2_f6_fd", 32'(frame_done), 32'd1);
    tick();
    chk("t2_f7_busy", 32'(busy), 32'd0);
    chk("t2_f7_valid", 32'(a_valid), 32'h0);

    // start with k_len == 0
    start = 1'b1; k_len = 5'd0; in_valid = 1'b1; in_data = vec(8'h7, 8'h7, 8'h7, 8'h7);
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_valid", 32'(a_valid), 32'h0);
    chk("t3_fd", 32'(frame_done), 32'd0);
    tick();
    chk("t3_busy_later", 32'(busy), 32'd0);

    // k_len above K_MAX saturates to 16 vectors
    start = 1'b1; k_len = 5'd20;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("sat_in_ready", 32'(in_ready), 32'd0);
    chk("sat_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    chk("sat_fd", 32'(frame_done), 32'd1);
    chk("sat_lane3_last", 32'(lane(3)), 32'd0);
    tick();
    chk("sat_idle", 32'(busy), 32'd0);

    // clear in DRAIN with data in flight
    start = 1'b1; k_len = 5'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = vec(8'h41, 8'h42, 8'h43, 8'h44);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4_inflight_valid", 32'(a_valid), 32'b0010);
    chk("t4_inflight_lane1", 32'(lane(1)), 32'h42);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clr_a_out", a_out, 32'h0);
    chk("t4_clr_valid", 32'(a_valid), 32'h0);
    chk("t4_clr_busy", 32'(busy), 32'd0);
    chk("t4_clr_fd", 32'(frame_done), 32'd0);
    tick();
    chk("t4_clr_fd_after", 32'(frame_done), 32'd0);
    chk("t4_clr_valid_after", 32'(a_valid), 32'h0);

    // start and in_valid together in IDLE: only start takes effect
    start = 1'b1; k_len = 5'd1; in_valid = 1'b1; in_data = vec(8'h51, 8'h52, 8'h53, 8'h54);
    tick();
    start = 1'b0;
    chk("t5_same_valid", 32'(a_valid), 32'h0);
    chk("t5_same_busy", 32'(busy), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t5_same_lane0", 32'(lane(0)), 32'h51);
    chk("t5_same_valid2", 32'(a_valid), 32'b0001);
    tick();
    tick();
    tick();
    chk("t5_same_fd", 32'(frame_done), 32'd1);
    tick();

    // Async rst mid-FEED
    start = 1'b1; k_len = 5'd4;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = vec(8'h61, 8'h62, 8'h63, 8'h64);
    tick();
    tick();
    chk("t4_pre_rst_valid", 32'(a_valid), 32'b0011);
    rst = 1'b1;
    #1;
    chk("t4_rst_a_out", a_out, 32'h0);
    chk("t4_rst_valid", 32'(a_valid), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t4_post_rst_busy", 32'(busy), 32'd0);

`ifdef FEEDER_CNT_EN
    chk("cnt_after_rst", 32'(frame_cnt), 32'd0);
    run_frame();
    run_frame();
    run_frame();
    chk("cnt_three", 32'(frame_cnt), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cnt_kept_by_clear", 32'(frame_cnt), 32'd3);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    chk("cnt_preload", 32'(frame_cnt), 32'hFFFF);
    run_frame();
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
